ps2_scancode: RTL and testbench
===============================

PS2_SCANCODE -- requirements
Module: ps2_scancode

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 42000, giving the clk cycles without a PS/2 falling edge before a partial frame is abandoned.
REQ-002 SHALL have parameter FILTER_LEN, default 8, giving the clk cycles a synchronized ps2_clk level must be stable before it is accepted.
REQ-003 SHALL have port clk, input, 1 bit: system clock, rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port ps2_clk, input, 1 bit: raw keyboard clock line, asynchronous to clk.
REQ-006 SHALL have port ps2_data, input, 1 bit: raw keyboard data line, asynchronous to clk.
REQ-007 SHALL have port ps2_key, output, 11 bits: [10] strobe, [9] break, [8] extended, [7:0] scancode.
REQ-008 SHALL have port err, output, 1 bit: one-cycle pulse on a parity, start, stop or timeout error.
REQ-009 SHALL have port diag, output, 8 bits: last raw byte received with good parity.

Function
REQ-010 SHALL pass ps2_clk and ps2_data each through a 2-flop synchronizer, then filter ps2_clk per FILTER_LEN.
REQ-011 SHALL sample data on each filtered ps2_clk falling edge; FSM states are IDLE, DATA, PARITY, STOP.
REQ-012 IDLE -> DATA on an edge with data=0; an edge with data=1 in IDLE SHALL pulse err and stay in IDLE.
REQ-013 DATA SHALL shift 8 bits LSB first, using a 3-bit counter, then go to PARITY.
REQ-014 PARITY SHALL require odd parity over the 8 data bits plus the parity bit; a mismatch is recorded and the FSM SHALL still go to STOP.
REQ-015 STOP with data=1 and good parity SHALL deliver the byte; otherwise it SHALL pulse err and discard the byte. STOP always returns to IDLE.
REQ-016 Byte E0 SHALL set a pending-extended flag and byte F0 a pending-break flag; neither produces a strobe.
REQ-017 Any other byte SHALL drive ps2_key[9:0] = {pending break, pending ext, byte} and assert ps2_key[10] high for exactly one clk, then clear both flags.
REQ-018 The strobe SHALL occur 1 clk after the stop-bit edge is accepted; ps2_key[9:0] SHALL hold until the next strobe.
REQ-019 In any state other than IDLE, TIMEOUT_CYCLES without an edge SHALL:
  - pulse err;
  - clear the shift register, bit counter and prefix flags;
  - return the FSM to IDLE.
REQ-020 Bytes AA (self-test pass), FA (ack), EE (echo), FE (resend) and 00/FF (overrun) with no pending prefix SHALL update diag only and produce no strobe.
REQ-021 A strobe and err SHALL never be asserted in the same cycle.

Reset
REQ-022 On reset low, asynchronously:
  - ps2_key=0, err=0, diag=0;
  - FSM=IDLE, counters=0, prefix flags=0;
  - synchronizer and filter outputs=1 (idle bus).
REQ-023 A reset asserted mid-frame SHALL discard the partial frame; the first strobe after release SHALL come from a complete new frame.

Configuration
REQ-024 With macro PS2_PAUSE_SEQ_EN defined:
  - the 8-byte sequence E1 14 77 E1 F0 14 F0 77 SHALL produce exactly one strobe with ps2_key[9:0]={0,1,77} on its last byte;
  - any byte other than the expected next one SHALL abort the sequence silently.
REQ-025 Without PS2_PAUSE_SEQ_EN, byte E1 SHALL be dropped and the following bytes decoded normally per REQ-016/017.

Structure
REQ-026 Shared package ps2_pkg SHALL hold:
  - FSM state encoding;
  - prefix byte constants (E0, F0, E1);
  - the REQ-020 special byte list;
  - ps2_key bit-index constants.
REQ-027 SHALL contain one sub-module ps2_filter (2-flop synchronizer plus stability filter plus falling-edge pulse), instantiated once for ps2_clk; ps2_data uses the synchronizer only.

Verification
REQ-028 Frame 1C (start 0, LSB-first data, parity 0, stop 1) -> single strobe, ps2_key=11'h41C, diag=1C.
REQ-029 Frames E0,F0,75 -> one strobe only, ps2_key=11'h775; a following 75 -> ps2_key=11'h475.
REQ-030 Frame 1C with parity forced to 1 -> err pulse, no strobe, diag unchanged.
REQ-031 Send 5 data bits, then idle 42000 cycles -> err pulse, FSM IDLE; next full frame 29 -> ps2_key=11'h429.
REQ-032 With PS2_PAUSE_SEQ_EN, Pause sequence -> exactly one strobe, ps2_key=11'h577; without it -> strobes 414, 477, 614, 677.
REQ-033 Reset pulsed low after 4 data bits of 1C -> outputs 0 at once; a complete frame 05 after release -> ps2_key=11'h405.

Source files
------------

// File: rtl/ps2_pkg.sv
// ps2_pkg -- definitions shared by the PS/2 scancode receiver.
//   * receive FSM state encoding
//   * prefix bytes (E0 extended, F0 break, E1 pause)
//   * keyboard status bytes that never reach ps2_key when no prefix is pending
//   * bit positions inside the 11-bit ps2_key output
//   * the Pause key byte sequence, used when PS2_PAUSE_SEQ_EN is defined
package ps2_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } ps2_state_t;

    localparam logic [7:0] BYTE_EXT    = 8'hE0;
    localparam logic [7:0] BYTE_BRK    = 8'hF0;
    localparam logic [7:0] BYTE_PAUSE  = 8'hE1;

    localparam logic [7:0] BYTE_BAT_OK = 8'hAA;
    localparam logic [7:0] BYTE_ACK    = 8'hFA;
    localparam logic [7:0] BYTE_ECHO   = 8'hEE;
    localparam logic [7:0] BYTE_RESEND = 8'hFE;
    localparam logic [7:0] BYTE_OVR_LO = 8'h00;
    localparam logic [7:0] BYTE_OVR_HI = 8'hFF;

    localparam int KEY_W      = 11;
    localparam int KEY_STROBE = 10;
    localparam int KEY_BREAK  = 9;
    localparam int KEY_EXT    = 8;

    // Code reported for a completed Pause sequence: extended, make, 77.
    localparam logic [7:0] PAUSE_CODE = 8'h77;

    function automatic logic is_status_byte(input logic [7:0] b);
        return (b == BYTE_BAT_OK) || (b == BYTE_ACK)    || (b == BYTE_ECHO) ||
               (b == BYTE_RESEND) || (b == BYTE_OVR_LO) || (b == BYTE_OVR_HI);
    endfunction

    // Byte expected at position idx of E1 14 77 E1 F0 14 F0 77.
    function automatic logic [7:0] pause_byte(input logic [2:0] idx);
        logic [7:0] b;
        case (idx)
            3'd0:    b = 8'hE1;
            3'd1:    b = 8'h14;
            3'd2:    b = 8'h77;
            3'd3:    b = 8'hE1;
            3'd4:    b = 8'hF0;
            3'd5:    b = 8'h14;
            3'd6:    b = 8'hF0;
            default: b = 8'h77;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/ps2_filter.sv
// ps2_filter -- 2-flop synchronizer, stability filter and falling-edge pulse
// for the PS/2 clock line.
//   clk   : system clock
//   reset : asynchronous, active-low; synchronizer and filter reset to 1 (idle bus)
//   din   : raw asynchronous input
//   fall  : one-cycle pulse when the filtered level goes 1 -> 0
// The filtered level only follows the synchronized input after it has
// differed from the current filtered level for FILTER_LEN consecutive cycles.
module ps2_filter #(
    parameter int FILTER_LEN = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic fall
);

    localparam int CNT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_LEN - 1);

    logic [1:0]       sync_q, sync_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             filt_q, filt_d;
    logic             fall_q, fall_d;

    always_comb begin
        sync_d = {sync_q[0], din};
        cnt_d  = cnt_q;
        filt_d = filt_q;
        fall_d = 1'b0;
        if (sync_q[1] == filt_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            filt_d = sync_q[1];
            cnt_d  = '0;
            fall_d = filt_q;    // old level 1 means this change is a fall
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q <= 2'b11;
            cnt_q  <= '0;
            filt_q <= 1'b1;
            fall_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            cnt_q  <= cnt_d;
            filt_q <= filt_d;
            fall_q <= fall_d;
        end
    end

    assign fall = fall_q;

endmodule

// File: rtl/ps2_scancode.sv
// ps2_scancode -- PS/2 keyboard receiver and scancode-set-2 prefix decoder.
//   clk      : system clock, rising edge
//   reset    : asynchronous, active-low
//   ps2_clk  : raw keyboard clock (asynchronous)
//   ps2_data : raw keyboard data (asynchronous)
//   ps2_key  : [10] one-cycle strobe, [9] break, [8] extended, [7:0] scancode;
//              [9:0] hold between strobes
//   err      : one-cycle pulse on start, parity, stop or timeout error
//   diag     : last byte accepted by the receiver
// Optional build macro PS2_PAUSE_SEQ_EN: recognise the 8-byte Pause sequence
// and report it as a single extended make of code 77. Without it E1 is
// dropped and the remaining bytes decode as ordinary keys.
module ps2_scancode
    import ps2_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 42000,
    parameter int FILTER_LEN     = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ps2_clk,
    input  logic              ps2_data,
    output logic [KEY_W-1:0]  ps2_key,
    output logic              err,
    output logic [7:0]        diag
);

    localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    logic              ps2_fall;
    logic [1:0]        data_sync_q, data_sync_d;
    logic              data_bit;

    ps2_state_t        state_q, state_d;
    logic [7:0]        shift_q, shift_d;
    logic [2:0]        bit_cnt_q, bit_cnt_d;
    logic              par_err_q, par_err_d;
    logic              ext_q, ext_d;
    logic              brk_q, brk_d;
    logic [KEY_STROBE-1:0] key_q, key_d;
    logic              strobe_q, strobe_d;
    logic              err_q, err_d;
    logic [7:0]        diag_q, diag_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d;
    logic              byte_ok;
    logic              decode_normal;
`ifdef PS2_PAUSE_SEQ_EN
    logic [2:0]        pause_idx_q, pause_idx_d;
`endif

    ps2_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
        .clk   (clk),
        .reset (reset),
        .din   (ps2_clk),
        .fall  (ps2_fall)
    );

    assign data_bit = data_sync_q[1];

    always_comb begin
        data_sync_d   = {data_sync_q[0], ps2_data};
        state_d       = state_q;
        shift_d       = shift_q;
        bit_cnt_d     = bit_cnt_q;
        par_err_d     = par_err_q;
        ext_d         = ext_q;
        brk_d         = brk_q;
        key_d         = key_q;
        strobe_d      = 1'b0;
        err_d         = 1'b0;
        diag_d        = diag_q;
        tmo_d         = tmo_q;
        byte_ok       = 1'b0;
        decode_normal = 1'b0;
`ifdef PS2_PAUSE_SEQ_EN
        pause_idx_d   = pause_idx_q;
`endif

        if (ps2_fall) begin
            tmo_d = '0;
            case (state_q)
                ST_IDLE: begin
                    if (!data_bit) begin
                        state_d   = ST_DATA;
                        bit_cnt_d = '0;
                    end else begin
                        err_d = 1'b1;           // bad start bit
                    end
                end
                ST_DATA: begin
                    shift_d   = {data_bit, shift_q[7:1]};   // LSB arrives first
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = ST_PARITY;
                    end
                end
                ST_PARITY: begin
                    // Odd parity: the nine bits must XOR to 1.
                    par_err_d = ~(^shift_q ^ data_bit);
                    state_d   = ST_STOP;
                end
                default: begin  // ST_STOP
                    state_d = ST_IDLE;
                    if (data_bit && !par_err_q) begin
                        byte_ok = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            endcase
        end else if (state_q != ST_IDLE) begin
            if (tmo_q == TMO_LAST) begin
                err_d     = 1'b1;
                state_d   = ST_IDLE;
                shift_d   = '0;
                bit_cnt_d = '0;
                ext_d     = 1'b0;
                brk_d     = 1'b0;
                tmo_d     = '0;
`ifdef PS2_PAUSE_SEQ_EN
                pause_idx_d = '0;
`endif
            end else begin
                tmo_d = tmo_q + 1'b1;
            end
        end else begin
            tmo_d = '0;
        end

        if (byte_ok) begin
            diag_d        = shift_q;
            decode_normal = 1'b1;
`ifdef PS2_PAUSE_SEQ_EN
            if (pause_idx_q != 3'd0) begin
                if (shift_q == pause_byte(pause_idx_q)) begin
                    decode_normal = 1'b0;
                    pause_idx_d   = pause_idx_q + 1'b1;
                    if (pause_idx_q == 3'd7) begin
                        strobe_d    = 1'b1;
                        key_d       = {1'b0, 1'b1, PAUSE_CODE};
                        ext_d       = 1'b0;
                        brk_d       = 1'b0;
                        pause_idx_d = '0;
                    end
                end else begin
                    // Off-sequence byte: forget the sequence, decode the byte.
                    pause_idx_d = '0;
                end
            end
`endif
            if (decode_normal) begin
                if (shift_q == BYTE_EXT) begin
                    ext_d = 1'b1;
                end else if (shift_q == BYTE_BRK) begin
                    brk_d = 1'b1;
                end else if (shift_q == BYTE_PAUSE) begin
`ifdef PS2_PAUSE_SEQ_EN
                    pause_idx_d = 3'd1;
`endif
                end else if (is_status_byte(shift_q) && !ext_q && !brk_q) begin
                    // Keyboard status byte: visible on diag only.
                end else begin
                    strobe_d = 1'b1;
                    key_d    = {brk_q, ext_q, shift_q};
                    ext_d    = 1'b0;
                    brk_d    = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data_sync_q <= 2'b11;
            state_q     <= ST_IDLE;
            shift_q     <= '0;
            bit_cnt_q   <= '0;
            par_err_q   <= 1'b0;
            ext_q       <= 1'b0;
            brk_q       <= 1'b0;
            key_q       <= '0;
            strobe_q    <= 1'b0;
            err_q       <= 1'b0;
            diag_q      <= '0;
            tmo_q       <= '0;
`ifdef PS2_PAUSE_SEQ_EN
            pause_idx_q <= '0;
`endif
        end else begin
            data_sync_q <= data_sync_d;
            state_q     <= state_d;
            shift_q     <= shift_d;
            bit_cnt_q   <= bit_cnt_d;
            par_err_q   <= par_err_d;
            ext_q       <= ext_d;
            brk_q       <= brk_d;
            key_q       <= key_d;
            strobe_q    <= strobe_d;
            err_q       <= err_d;
            diag_q      <= diag_d;
            tmo_q       <= tmo_d;
`ifdef PS2_PAUSE_SEQ_EN
            pause_idx_q <= pause_idx_d;
`endif
        end
    end

    assign ps2_key[KEY_STROBE]     = strobe_q;
    assign ps2_key[KEY_STROBE-1:0] = key_q;
    assign err                     = err_q;
    assign diag                    = diag_q;

endmodule

// File: tb/tb_ps2_scancode.sv
// tb_ps2_scancode -- directed stimulus for ps2_scancode with a scoreboard.
// The stimulus pushes each expected strobe value or error pulse into a
// queue; a monitor pops and compares whenever the DUT shows a strobe or err.
// Honours PS2_PAUSE_SEQ_EN to choose the expected Pause-sequence result.
module tb_ps2_scancode;

    localparam int H = 25;  // PS/2 half clock period, in system clocks

    typedef struct {
        bit         is_err;
        logic [10:0] key;
    } ev_t;

    logic        clk;
    logic        reset;
    logic        ps2_clk;
    logic        ps2_data;
    logic [10:0] ps2_key;
    logic        err;
    logic [7:0]  diag;

    ev_t exp_q[$];
    int  n_checks;
    int  n_pass;
    bit  mon_en;

    ps2_scancode dut (
        .clk      (clk),
        .reset    (reset),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .ps2_key  (ps2_key),
        .err      (err),
        .diag     (diag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [10:0] got, input logic [10:0] want);
        n_checks++;
        if (got === want) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h, expected %h", name, got, want);
        end
    endtask

    task automatic expect_key(input logic [10:0] k);
        ev_t e;
        e.is_err = 1'b0;
        e.key    = k;
        exp_q.push_back(e);
    endtask

    task automatic expect_err();
        ev_t e;
        e.is_err = 1'b1;
        e.key    = '0;
        exp_q.push_back(e);
    endtask

    task automatic ps2_bit(input logic v);
        ps2_data = v;
        repeat (H) @(negedge clk);
        ps2_clk = 1'b0;
        repeat (H) @(negedge clk);
        ps2_clk = 1'b1;
    endtask

    // Send the first nbits bits of a frame for byte b (start, 8 data, parity, stop).
    task automatic send_bits(input logic [7:0] b, input bit bad_par, input int nbits);
        logic [10:0] fr;
        fr = {1'b1, (~^b) ^ bad_par, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            ps2_bit(fr[i]);
        end
        ps2_data = 1'b1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        send_bits(b, 1'b0, 11);
        repeat (3 * H) @(negedge clk);
    endtask

    initial begin
        logic [7:0] pause_seq [8];
        ev_t e;
        n_checks = 0;
        n_pass   = 0;
        mon_en   = 1'b0;
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        reset    = 1'b1;
        pause_seq = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};

        // Monitor: one line per observed transaction, compared to the queue.
        fork
            forever begin
                @(negedge clk);
                if (mon_en && reset) begin
                    if (ps2_key[10] && err) begin
                        n_checks++;
                        $display("FAIL strobe_err_overlap: ps2_key=%h err=%b", ps2_key, err);
                    end else if (ps2_key[10] || err) begin
                        $display("t=%0t event strobe=%b err=%b ps2_key=%h", $time, ps2_key[10], err, ps2_key);
                        if (exp_q.size() == 0) begin
                            n_checks++;
                            $display("FAIL unexpected_event: ps2_key=%h err=%b, expected none", ps2_key, err);
                        end else begin
                            e = exp_q.pop_front();
                            if (e.is_err) chk("err_pulse", {10'd0, err & ~ps2_key[10]}, 11'd1);
                            else          chk("strobe_key", ps2_key, e.key);
                        end
                    end
                end
            end
        join_none

        // Reset state
        #3 reset = 1'b0;
        #2;
        chk("reset_key", ps2_key, 11'h000);
        chk("reset_err", {10'd0, err}, 11'd0);
        chk("reset_diag", {3'd0, diag}, 11'h000);
        repeat (4) @(negedge clk);
        reset  = 1'b1;
        mon_en = 1'b1;
        repeat (4) @(negedge clk);

        // Plain make code
        expect_key(11'h41C);
        send_byte(8'h1C);
        chk("diag_1c", {3'd0, diag}, 11'h01C);
        chk("key_hold", ps2_key, 11'h01C);

        // Extended break, then plain make of the same code
        expect_key(11'h775);
        send_byte(8'hE0);
        send_byte(8'hF0);
        send_byte(8'h75);
        expect_key(11'h475);
        send_byte(8'h75);
        chk("diag_75", {3'd0, diag}, 11'h075);

        // Parity error
        expect_err();
        send_bits(8'h1C, 1'b1, 11);
        repeat (3 * H) @(negedge clk);
        chk("diag_after_par_err", {3'd0, diag}, 11'h075);

        // Timeout after a partial frame: start + 5 data bits
        expect_err();
        send_bits(8'h29, 1'b0, 6);
        repeat (42200) @(negedge clk);
        expect_key(11'h429);
        send_byte(8'h29);

        // Status bytes: diag only
        send_byte(8'hAA);
        send_byte(8'hFA);
        chk("diag_status", {3'd0, diag}, 11'h0FA);

        // Edge in IDLE with data high: bad start bit
        expect_err();
        ps2_bit(1'b1);
        repeat (3 * H) @(negedge clk);

        // Pause sequence
`ifdef PS2_PAUSE_SEQ_EN
        expect_key(11'h577);
`else
        expect_key(11'h414);
        expect_key(11'h477);
        expect_key(11'h614);
        expect_key(11'h677);
`endif
        for (int i = 0; i < 8; i++) begin
            send_byte(pause_seq[i]);
        end

        // Reset mid-frame: start + 4 data bits of 1C
        send_bits(8'h1C, 1'b0, 5);
        reset    = 1'b0;
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        #1;
        chk("midreset_key", ps2_key, 11'h000);
        chk("midreset_diag", {3'd0, diag}, 11'h000);
        repeat (4) @(negedge clk);
        reset = 1'b1;
        repeat (4) @(negedge clk);
        expect_key(11'h405);
        send_byte(8'h05);
        chk("diag_05", {3'd0, diag}, 11'h005);

        // Drain: every expected event must have appeared
        for (int i = 0; i < 500 && exp_q.size() != 0; i++) begin
            @(negedge clk);
        end
        chk("events_outstanding", 11'(exp_q.size()), 11'd0);

        mon_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
